id_ex_hazard_stage: RTL and testbench

ID/EX pipeline register with integrated hazard detection and stall control for the 5-stage MIPS pipeline.
- Captures decoded operands, register numbers and control from ID.
- Detects load-use and branch-in-ID data hazards, stalls PC and IF/ID, and inserts bubbles into EX.
- Its ID_EX_RegisterRs/Rt/Rd, ID_EX_RegWrite and data outputs feed the forwarding unit and ALU muxes directly downstream.

---
 rtl/pipeline_pkg.sv | 21 ++
 rtl/id_ex_hazard_stage_hazard_detect.sv | 53 +++++
 rtl/id_ex_hazard_stage.sv | 127 ++++++++++++
 tb/tb_id_ex_hazard_stage.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_pkg
// Purpose  : Shared types and constants for the ID/EX hazard stage.
// Revision : 1.0
// ============================================================================
package pipeline_pkg;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Register $zero never carries a dependency.
  localparam int REG_ZERO = 0;

  // Control bundle value for a bubble (no RegWrite, no MemWrite, ...).
  localparam int CTRL_BUBBLE = 0;

endpackage
`default_nettype wire

// File: rtl/id_ex_hazard_stage_hazard_detect.sv
`default_nettype none
// ============================================================================
// Module   : hazard_detect
// Purpose  : Combinational load-use / branch-in-ID hazard classifier.
// Revision : 1.0
// ============================================================================
module hazard_detect
  import pipeline_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic [REG_ADDR_WIDTH-1:0] i_idRs,
  input  logic [REG_ADDR_WIDTH-1:0] i_idRt,
  input  logic                      i_idUsesRs,
  input  logic                      i_idUsesRt,
  input  logic                      i_idBranch,
  input  logic                      i_exValid,
  input  logic                      i_exRegWrite,
  input  logic                      i_exMemRead,
  input  logic [REG_ADDR_WIDTH-1:0] i_exRd,
  input  logic                      i_memMemRead,
  input  logic [REG_ADDR_WIDTH-1:0] i_memRd,
  output logic                      o_stallReq,
  output logic                      o_needHold
);

  localparam logic [REG_ADDR_WIDTH-1:0] c_zero = REG_ADDR_WIDTH'(REG_ZERO);

  logic w_exMatch;
  logic w_memMatch;
  logic w_lu;
  logic w_ba;
  logic w_bl2;
  logic w_bl1;

  assign w_exMatch  = i_exValid & (i_exRd != c_zero) &
                      ((i_idUsesRs & (i_idRs == i_exRd)) |
                       (i_idUsesRt & (i_idRt == i_exRd)));
  assign w_memMatch = (i_memRd != c_zero) &
                      ((i_idUsesRs & (i_idRs == i_memRd)) |
                       (i_idUsesRt & (i_idRt == i_memRd)));

  assign w_lu  = i_exMemRead & w_exMatch;
  assign w_ba  = i_idBranch & i_exRegWrite & ~i_exMemRead & w_exMatch;
  assign w_bl2 = i_idBranch & i_exMemRead & w_exMatch;
  assign w_bl1 = i_idBranch & i_memMemRead & w_memMatch;

  assign o_stallReq = w_lu | w_ba | w_bl2 | w_bl1;
  // A branch waiting on a load still in EX needs a second bubble.
  assign o_needHold = w_bl2;

endmodule
`default_nettype wire

// File: rtl/id_ex_hazard_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_hazard_stage
// Purpose  : ID/EX pipeline register with hazard stall control and counter.
// Revision : 1.0
// ============================================================================
module id_ex_hazard_stage
  import pipeline_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int REG_ADDR_WIDTH  = 5,
  parameter int CTRL_WIDTH      = 8,
  parameter int STALL_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [REG_ADDR_WIDTH-1:0]  ID_RegisterRs,
  input  logic [REG_ADDR_WIDTH-1:0]  ID_RegisterRt,
  input  logic [REG_ADDR_WIDTH-1:0]  ID_RegisterRd,
  input  logic                       ID_UsesRs,
  input  logic                       ID_UsesRt,
  input  logic                       ID_Branch,
  input  logic                       ID_RegWrite,
  input  logic                       ID_MemRead,
  input  logic [CTRL_WIDTH-1:0]      ID_Ctrl,
  input  logic [DATA_WIDTH-1:0]      ID_ReadData1,
  input  logic [DATA_WIDTH-1:0]      ID_ReadData2,
  input  logic [DATA_WIDTH-1:0]      ID_Imm,
  input  logic                       EX_MEM_MemRead,
  input  logic [REG_ADDR_WIDTH-1:0]  EX_MEM_RegisterRd,
  input  logic                       EX_Flush,
  output logic                       PCWrite,
  output logic                       IF_ID_Write,
  output logic [REG_ADDR_WIDTH-1:0]  ID_EX_RegisterRs,
  output logic [REG_ADDR_WIDTH-1:0]  ID_EX_RegisterRt,
  output logic [REG_ADDR_WIDTH-1:0]  ID_EX_RegisterRd,
  output logic                       ID_EX_RegWrite,
  output logic                       ID_EX_MemRead,
  output logic [CTRL_WIDTH-1:0]      ID_EX_Ctrl,
  output logic [DATA_WIDTH-1:0]      ID_EX_ReadData1,
  output logic [DATA_WIDTH-1:0]      ID_EX_ReadData2,
  output logic [DATA_WIDTH-1:0]      ID_EX_Imm,
  output logic                       ID_EX_Valid,
  output logic [STALL_CNT_WIDTH-1:0] StallCount
);

  localparam logic [CTRL_WIDTH-1:0]      c_ctrlBubble = CTRL_WIDTH'(CTRL_BUBBLE);
  localparam logic [STALL_CNT_WIDTH-1:0] c_cntMax     = '1;

  state_t r_state;
  logic   w_stallReq;
  logic   w_needHold;
  logic   w_stall;

  hazard_detect #(
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
  ) u_hazard (
    .i_idRs       (ID_RegisterRs),
    .i_idRt       (ID_RegisterRt),
    .i_idUsesRs   (ID_UsesRs),
    .i_idUsesRt   (ID_UsesRt),
    .i_idBranch   (ID_Branch),
    .i_exValid    (ID_EX_Valid),
    .i_exRegWrite (ID_EX_RegWrite),
    .i_exMemRead  (ID_EX_MemRead),
    .i_exRd       (ID_EX_RegisterRd),
    .i_memMemRead (EX_MEM_MemRead),
    .i_memRd      (EX_MEM_RegisterRd),
    .o_stallReq   (w_stallReq),
    .o_needHold   (w_needHold)
  );

  assign w_stall     = ((r_state == RUN) & w_stallReq) | (r_state == HOLD);
  // A flush hands the front end to the redirect, so never freeze it then.
  assign PCWrite     = EX_Flush | ~w_stall;
  assign IF_ID_Write = EX_Flush | ~w_stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state          <= RUN;
      StallCount       <= '0;
      ID_EX_Valid      <= 1'b0;
      ID_EX_RegisterRs <= '0;
      ID_EX_RegisterRt <= '0;
      ID_EX_RegisterRd <= '0;
      ID_EX_RegWrite   <= 1'b0;
      ID_EX_MemRead    <= 1'b0;
      ID_EX_Ctrl       <= c_ctrlBubble;
      ID_EX_ReadData1  <= '0;
      ID_EX_ReadData2  <= '0;
      ID_EX_Imm        <= '0;
    end else if (EX_Flush || w_stall) begin
      if (EX_Flush) begin
        r_state <= RUN;
      end else begin
        r_state <= ((r_state == RUN) && w_needHold) ? HOLD : RUN;
        if (StallCount != c_cntMax) begin
          StallCount <= StallCount + 1'b1;
        end
      end
      ID_EX_Valid      <= 1'b0;
      ID_EX_RegisterRs <= '0;
      ID_EX_RegisterRt <= '0;
      ID_EX_RegisterRd <= '0;
      ID_EX_RegWrite   <= 1'b0;
      ID_EX_MemRead    <= 1'b0;
      ID_EX_Ctrl       <= c_ctrlBubble;
      ID_EX_ReadData1  <= '0;
      ID_EX_ReadData2  <= '0;
      ID_EX_Imm        <= '0;
    end else begin
      r_state          <= RUN;
      ID_EX_Valid      <= 1'b1;
      ID_EX_RegisterRs <= ID_RegisterRs;
      ID_EX_RegisterRt <= ID_RegisterRt;
      ID_EX_RegisterRd <= ID_RegisterRd;
      ID_EX_RegWrite   <= ID_RegWrite;
      ID_EX_MemRead    <= ID_MemRead;
      ID_EX_Ctrl       <= ID_Ctrl;
      ID_EX_ReadData1  <= ID_ReadData1;
      ID_EX_ReadData2  <= ID_ReadData2;
      ID_EX_Imm        <= ID_Imm;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_id_ex_hazard_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_hazard_stage
// Purpose  : Directed and random checks of id_ex_hazard_stage against a model.
// Revision : 1.0
// ============================================================================
module tb_id_ex_hazard_stage;

  localparam int DW = 32;
  localparam int RW = 5;
  localparam int CW = 8;
  localparam int SW = 6;
  localparam int CNT_MAX = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [RW-1:0] ID_RegisterRs, ID_RegisterRt, ID_RegisterRd;
  logic          ID_UsesRs, ID_UsesRt, ID_Branch, ID_RegWrite, ID_MemRead;
  logic [CW-1:0] ID_Ctrl;
  logic [DW-1:0] ID_ReadData1, ID_ReadData2, ID_Imm;
  logic          EX_MEM_MemRead;
  logic [RW-1:0] EX_MEM_RegisterRd;
  logic          EX_Flush;
  logic          PCWrite, IF_ID_Write;
  logic [RW-1:0] ID_EX_RegisterRs, ID_EX_RegisterRt, ID_EX_RegisterRd;
  logic          ID_EX_RegWrite, ID_EX_MemRead, ID_EX_Valid;
  logic [CW-1:0] ID_EX_Ctrl;
  logic [DW-1:0] ID_EX_ReadData1, ID_EX_ReadData2, ID_EX_Imm;
  logic [SW-1:0] StallCount;

  always #5 clk = ~clk;

  id_ex_hazard_stage #(
    .DATA_WIDTH(DW), .REG_ADDR_WIDTH(RW), .CTRL_WIDTH(CW), .STALL_CNT_WIDTH(SW)
  ) dut (
    .clk(clk), .reset(reset),
    .ID_RegisterRs(ID_RegisterRs), .ID_RegisterRt(ID_RegisterRt),
    .ID_RegisterRd(ID_RegisterRd), .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt),
    .ID_Branch(ID_Branch), .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead),
    .ID_Ctrl(ID_Ctrl), .ID_ReadData1(ID_ReadData1), .ID_ReadData2(ID_ReadData2),
    .ID_Imm(ID_Imm), .EX_MEM_MemRead(EX_MEM_MemRead),
    .EX_MEM_RegisterRd(EX_MEM_RegisterRd), .EX_Flush(EX_Flush),
    .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write),
    .ID_EX_RegisterRs(ID_EX_RegisterRs), .ID_EX_RegisterRt(ID_EX_RegisterRt),
    .ID_EX_RegisterRd(ID_EX_RegisterRd), .ID_EX_RegWrite(ID_EX_RegWrite),
    .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_Ctrl(ID_EX_Ctrl),
    .ID_EX_ReadData1(ID_EX_ReadData1), .ID_EX_ReadData2(ID_EX_ReadData2),
    .ID_EX_Imm(ID_EX_Imm), .ID_EX_Valid(ID_EX_Valid), .StallCount(StallCount)
  );

  // Model: contents of the EX slot, remaining forced stalls, stall total.
  typedef struct {
    bit valid; int rs; int rt; int rd; bit regWrite; bit memRead;
    int ctrl; longint d1; longint d2; longint imm;
  } ex_t;

  ex_t m;
  int  holdLeft;
  int  cnt;
  int  checks = 0;
  int  errors = 0;
  bit  lastPcw;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit dep(input int dst);
    return dst != 0 && ((ID_UsesRs && int'(ID_RegisterRs) == dst) ||
                        (ID_UsesRt && int'(ID_RegisterRt) == dst));
  endfunction

  function automatic bit model_bl2();
    return ID_Branch && m.valid && m.memRead && dep(m.rd);
  endfunction

  function automatic bit model_stall();
    bit lu, ba, bl1;
    if (holdLeft > 0) return 1'b1;
    lu  = m.valid && m.memRead && dep(m.rd);
    ba  = ID_Branch && m.valid && m.regWrite && !m.memRead && dep(m.rd);
    bl1 = ID_Branch && EX_MEM_MemRead && dep(int'(EX_MEM_RegisterRd));
    return lu || ba || model_bl2() || bl1;
  endfunction

  function automatic ex_t bubble();
    ex_t b;
    b = '{default: 0};
    return b;
  endfunction

  task automatic model_reset();
    m = bubble();
    holdLeft = 0;
    cnt = 0;
  endtask

  task automatic check_regs(input string tag);
    check_value({tag, "_valid"}, 64'(ID_EX_Valid), 64'(m.valid));
    check_value({tag, "_rs"}, 64'(ID_EX_RegisterRs), 64'(m.rs));
    check_value({tag, "_rt"}, 64'(ID_EX_RegisterRt), 64'(m.rt));
    check_value({tag, "_rd"}, 64'(ID_EX_RegisterRd), 64'(m.rd));
    check_value({tag, "_regwr"}, 64'(ID_EX_RegWrite), 64'(m.regWrite));
    check_value({tag, "_memrd"}, 64'(ID_EX_MemRead), 64'(m.memRead));
    check_value({tag, "_ctrl"}, 64'(ID_EX_Ctrl), 64'(m.ctrl));
    check_value({tag, "_d1"}, 64'(ID_EX_ReadData1), 64'(m.d1));
    check_value({tag, "_d2"}, 64'(ID_EX_ReadData2), 64'(m.d2));
    check_value({tag, "_imm"}, 64'(ID_EX_Imm), 64'(m.imm));
    check_value({tag, "_cnt"}, 64'(StallCount), 64'(cnt));
  endtask

  // One clock: inputs are already applied at the falling edge.
  task automatic step(input string tag);
    bit st, hold2;
    #1;
    st    = model_stall();
    hold2 = (holdLeft == 0) && model_bl2();
    lastPcw = PCWrite;
    check_value({tag, "_pcw"}, 64'(PCWrite), 64'(EX_Flush || !st));
    check_value({tag, "_ifid"}, 64'(IF_ID_Write), 64'(EX_Flush || !st));
    @(posedge clk);
    if (EX_Flush) begin
      m = bubble();
      holdLeft = 0;
    end else if (st) begin
      m = bubble();
      holdLeft = (holdLeft > 0) ? 0 : (hold2 ? 1 : 0);
      if (cnt < CNT_MAX) cnt++;
    end else begin
      m.valid = 1; m.rs = ID_RegisterRs; m.rt = ID_RegisterRt; m.rd = ID_RegisterRd;
      m.regWrite = ID_RegWrite; m.memRead = ID_MemRead; m.ctrl = ID_Ctrl;
      m.d1 = ID_ReadData1; m.d2 = ID_ReadData2; m.imm = ID_Imm;
    end
    #1;
    check_regs(tag);
    @(negedge clk);
  endtask

  task automatic idle();
    ID_RegisterRs = 0; ID_RegisterRt = 0; ID_RegisterRd = 0;
    ID_UsesRs = 0; ID_UsesRt = 0; ID_Branch = 0; ID_RegWrite = 0; ID_MemRead = 0;
    ID_Ctrl = 8'h5A; ID_ReadData1 = 32'h1111_0001; ID_ReadData2 = 32'h2222_0002;
    ID_Imm = 32'hFFFF_FFFC; EX_MEM_MemRead = 0; EX_MEM_RegisterRd = 0; EX_Flush = 0;
  endtask

  task automatic load(input int rd);
    idle(); ID_MemRead = 1; ID_RegWrite = 1; ID_RegisterRd = RW'(rd);
    ID_RegisterRs = 5'd29; ID_UsesRs = 1;
  endtask

  task automatic branch_rs(input int rs);
    idle(); ID_Branch = 1; ID_RegisterRs = RW'(rs); ID_UsesRs = 1;
  endtask

  int base;

  initial begin
    idle();
    reset = 0;
    model_reset();
    #12;
    check_regs("reset");
    check_value("reset_pcw", 64'(PCWrite), 64'd1);
    @(negedge clk);
    reset = 1;

    // Load-use: one bubble, then the consumer is captured.
    load(8); step("t1_lw");
    idle(); ID_RegisterRs = 8; ID_UsesRs = 1; ID_RegWrite = 1; ID_RegisterRd = 10;
    step("t1_stall");
    check_value("t1_pcw0", 64'(lastPcw), 64'd0);
    check_value("t1_bubble", 64'(ID_EX_Valid), 64'd0);
    step("t1_go");
    check_value("t1_pcw1", 64'(lastPcw), 64'd1);
    check_value("t1_cap", 64'(ID_EX_Valid), 64'd1);
    check_value("t1_cnt", 64'(StallCount), 64'd1);

    // Branch on load in EX: two stalls.
    base = StallCount;
    load(9); step("t2_lw");
    branch_rs(9); step("t2_s1");
    check_value("t2_pcw_s1", 64'(lastPcw), 64'd0);
    step("t2_s2");
    check_value("t2_pcw_s2", 64'(lastPcw), 64'd0);
    step("t2_go");
    check_value("t2_pcw_go", 64'(lastPcw), 64'd1);
    check_value("t2_cnt", 64'(StallCount), 64'(base + 2));

    // Branch on ALU result in EX, then on load in MEM behind a bubble.
    idle(); ID_RegWrite = 1; ID_RegisterRd = 5; step("t3_add");
    idle(); ID_Branch = 1; ID_RegisterRt = 5; ID_UsesRt = 1; step("t3_ba");
    check_value("t3_ba_pcw", 64'(lastPcw), 64'd0);
    step("t3_ba_go");
    idle(); EX_Flush = 1; step("t3_flush");
    branch_rs(5); EX_MEM_MemRead = 1; EX_MEM_RegisterRd = 5; step("t3_bl1");
    check_value("t3_bl1_pcw", 64'(lastPcw), 64'd0);
    EX_MEM_MemRead = 0; step("t3_bl1_go");

    // $zero and unused-source cases never stall.
    load(0); step("t4_lw0");
    idle(); ID_RegisterRs = 0; ID_UsesRs = 1; step("t4_r0");
    check_value("t4_r0_pcw", 64'(lastPcw), 64'd1);
    load(6); step("t4_lw6");
    idle(); ID_RegisterRs = 6; ID_UsesRs = 0; step("t4_nouse");
    check_value("t4_nouse_pcw", 64'(lastPcw), 64'd1);

    // Flush during HOLD.
    load(9); step("t5_lw");
    branch_rs(9); step("t5_s1");
    base = StallCount;
    EX_Flush = 1; step("t5_flush");
    check_value("t5_flush_pcw", 64'(lastPcw), 64'd1);
    check_value("t5_cnt", 64'(StallCount), 64'(base));
    EX_Flush = 0; step("t5_after");
    check_value("t5_run_pcw", 64'(lastPcw), 64'd1);

    // Continuous stalls saturate the counter.
    branch_rs(7); EX_MEM_MemRead = 1; EX_MEM_RegisterRd = 7;
    for (int i = 0; i < CNT_MAX + 8; i++) step("t6_sat");
    check_value("t6_sat_cnt", 64'(StallCount), 64'(CNT_MAX));

    // Asynchronous reset in the middle of HOLD.
    load(9); step("t6_lw");
    branch_rs(9); step("t6_hold");
    #2 reset = 0;
    model_reset();
    #1;
    check_regs("t6_arst");
    check_value("t6_arst_pcw", 64'(PCWrite), 64'd1);
    #1 reset = 1;
    @(negedge clk);

    for (int i = 0; i < 3000; i++) begin
      ID_RegisterRs     = RW'($urandom_range(0, 3));
      ID_RegisterRt     = RW'($urandom_range(0, 3));
      ID_RegisterRd     = RW'($urandom_range(0, 3));
      ID_UsesRs         = 1'($urandom);
      ID_UsesRt         = 1'($urandom);
      ID_Branch         = ($urandom_range(0, 3) == 0);
      ID_RegWrite       = 1'($urandom);
      ID_MemRead        = ($urandom_range(0, 2) == 0);
      ID_Ctrl           = CW'($urandom);
      ID_ReadData1      = $urandom;
      ID_ReadData2      = $urandom;
      ID_Imm            = $urandom;
      EX_MEM_MemRead    = ($urandom_range(0, 3) == 0);
      EX_MEM_RegisterRd = RW'($urandom_range(0, 3));
      EX_Flush          = ($urandom_range(0, 15) == 0);
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
